// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_param : 16x-oversampled UART receiver, parameterised framing,      |
// |                 valid/ready output with overrun and break reporting        |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module uart_rx_param #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_break
);
   localparam int c_DIV   = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
   localparam int c_DIV_W = $clog2(c_DIV + 1);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_START   = 3'd1;
   localparam logic [2:0] c_DATA    = 3'd2;
   localparam logic [2:0] c_PAR     = 3'd3;
   localparam logic [2:0] c_STOP    = 3'd4;
   localparam logic [2:0] c_BRKWAIT = 3'd5;

   logic                 r_rx_meta, r_rx_sync, r_rx_prev;
   logic [2:0]           r_state, w_state_nxt;
   logic [c_DIV_W-1:0]   r_div_cnt;
   logic [3:0]           r_tick_cnt;
   logic [3:0]           r_bit_cnt;
   logic                 r_stop_cnt;
   logic                 r_s7, r_s8;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_bit, r_all_low, r_ferr_acc;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_perr, r_ferr, r_overrun, r_break;

   logic w_fall, w_start, w_tick, w_t9, w_t15, w_bit;
   logic w_last_data, w_last_stop, w_decide, w_brk, w_ferr, w_odd, w_perr;
   logic w_load, w_drop, w_brk_pulse;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= uart_rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   assign w_fall      = r_rx_prev & ~r_rx_sync;
   assign w_start     = (r_state == c_IDLE) && w_fall;
   assign w_tick      = (r_div_cnt == c_DIV_W'(c_DIV - 1));
   assign w_t9        = w_tick && (r_tick_cnt == 4'd9);
   assign w_t15       = w_tick && (r_tick_cnt == 4'd15);
   // Majority vote of the samples at ticks 7, 8 and the current tick 9
   assign w_bit       = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);
   assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
   assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_decide    = (r_state == c_STOP) && w_t9 && w_last_stop;
   assign w_brk       = r_all_low & ~w_bit;
   assign w_ferr      = r_ferr_acc | ~w_bit;
   assign w_odd       = (^r_shift) ^ r_par_bit;
   assign w_perr      = (PARITY == 1) ? ~w_odd : (PARITY == 2) ? w_odd : 1'b0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= c_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:    if (w_fall) w_state_nxt = c_START;
         c_START:   if (w_t9 && w_bit) w_state_nxt = c_IDLE;
                    else if (w_t15) w_state_nxt = c_DATA;
         c_DATA:    if (w_t15 && w_last_data) w_state_nxt = (PARITY != 0) ? c_PAR : c_STOP;
         c_PAR:     if (w_t15) w_state_nxt = c_STOP;
         c_STOP:    if (w_decide) w_state_nxt = w_brk ? c_BRKWAIT : c_IDLE;
         c_BRKWAIT: if (w_tick && r_rx_sync && (r_tick_cnt == 4'd15)) w_state_nxt = c_IDLE;
         default:   w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_load      = w_decide && !w_brk && (!r_valid || i_ready);
      w_drop      = w_decide && !w_brk && r_valid && !i_ready;
      w_brk_pulse = w_decide && w_brk;
   end

   // In BRKWAIT the tick counter counts consecutive high ticks instead of bit phase
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt  <= '0;
         r_tick_cnt <= '0;
         r_s7       <= 1'b1;
         r_s8       <= 1'b1;
      end else begin
         r_div_cnt <= (w_start || w_tick) ? '0 : r_div_cnt + c_DIV_W'(1);
         if (w_start || w_brk_pulse)
            r_tick_cnt <= '0;
         else if (w_tick) begin
            if (r_state == c_BRKWAIT)
               r_tick_cnt <= r_rx_sync ? r_tick_cnt + 4'd1 : 4'd0;
            else
               r_tick_cnt <= r_tick_cnt + 4'd1;
         end
         if (w_tick && (r_tick_cnt == 4'd7)) r_s7 <= r_rx_sync;
         if (w_tick && (r_tick_cnt == 4'd8)) r_s8 <= r_rx_sync;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_par_bit  <= 1'b0;
         r_all_low  <= 1'b0;
         r_ferr_acc <= 1'b0;
      end else if (w_start) begin
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_par_bit  <= 1'b0;
         r_all_low  <= 1'b1;
         r_ferr_acc <= 1'b0;
      end else begin
         case (r_state)
            c_DATA: begin
               if (w_t9) begin
                  r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                  if (w_bit) r_all_low <= 1'b0;
               end
               if (w_t15) r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            c_PAR: begin
               if (w_t9) begin
                  r_par_bit <= w_bit;
                  if (w_bit) r_all_low <= 1'b0;
               end
            end
            c_STOP: begin
               if (w_t9) begin
                  if (w_bit) r_all_low  <= 1'b0;
                  else       r_ferr_acc <= 1'b1;
               end
               if (w_t15) r_stop_cnt <= r_stop_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         r_break   <= w_brk_pulse;
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= r_shift;
            r_perr  <= w_perr;
            r_ferr  <= w_ferr;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_data       = r_data;
   assign o_valid      = r_valid;
   assign o_parity_err = r_perr;
   assign o_frame_err  = r_ferr;
   assign o_overrun    = r_overrun;
   assign o_break      = r_break;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_param : scoreboard bench, 8N1 receiver and 8E1 receiver         |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_uart_rx_param;
   localparam int BT = 8680;

   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst_n = 1'b0;
   logic ready = 1'b1;
   logic rx0 = 1'b1, rx1 = 1'b1;
   logic [7:0] data0, data1;
   logic valid0, perr0, ferr0, ovr0, brk0;
   logic valid1, perr1, ferr1, ovr1, brk1;

   uart_rx_param dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .uart_rx(rx0), .o_data(data0), .o_valid(valid0),
      .i_ready(ready), .o_parity_err(perr0), .o_frame_err(ferr0),
      .o_overrun(ovr0), .o_break(brk0));

   uart_rx_param #(.PARITY(2)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .uart_rx(rx1), .o_data(data1), .o_valid(valid1),
      .i_ready(ready), .o_parity_err(perr1), .o_frame_err(ferr1),
      .o_overrun(ovr1), .o_break(brk1));

   int n_checks = 0;
   int n_fail = 0;
   logic [9:0] q0[$];
   logic [9:0] q1[$];
   int brk_cnt[2] = '{0, 0};
   int ovr_cnt[2] = '{0, 0};
   int exp_brk[2] = '{0, 0};
   int exp_ovr[2] = '{0, 0};

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void flag(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endfunction

   function automatic void drive(int sel, logic v);
      if (sel == 0) rx0 = v;
      else          rx1 = v;
   endfunction

   // Expected word layout: {parity_err, frame_err, data}
   task automatic send(input int sel, input logic [7:0] d, input logic pbit,
                       input logic stop_lvl, input bit drop);
      int         ones;
      bit         brk;
      logic [9:0] exp;
      logic       perr;
      ones = $countones(d) + ((sel == 1) ? int'(pbit) : 0);
      brk  = (d == 8'h00) && (sel == 0 || pbit == 1'b0) && (stop_lvl == 1'b0);
      perr = (sel == 1) && (ones % 2 == 1);
      exp  = {perr, ~stop_lvl, d};
      if (brk)       exp_brk[sel]++;
      else if (drop) exp_ovr[sel]++;
      else if (sel == 0) q0.push_back(exp);
      else               q1.push_back(exp);
      drive(sel, 1'b0); #BT;
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]); #BT;
      end
      if (sel == 1) begin
         drive(sel, pbit); #BT;
      end
      drive(sel, stop_lvl); #BT;
      drive(sel, 1'b1); #(2 * BT);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid0 && ready) begin
            if (q0.size() == 0) flag("dut0_spurious_valid");
            else check("dut0_word", {22'd0, perr0, ferr0, data0}, {22'd0, q0.pop_front()});
         end
         if (ovr0) ovr_cnt[0]++;
         if (brk0) brk_cnt[0]++;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid1 && ready) begin
            if (q1.size() == 0) flag("dut1_spurious_valid");
            else check("dut1_word", {22'd0, perr1, ferr1, data1}, {22'd0, q1.pop_front()});
         end
         if (ovr1) ovr_cnt[1]++;
         if (brk1) brk_cnt[1]++;
      end
   end

   initial begin
      #4ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset_out0", {data0, valid0, perr0, ferr0, ovr0, brk0}, 0);
      check("reset_out1", {data1, valid1, perr1, ferr1, ovr1, brk1}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      #BT;

      send(0, 8'h5A, 1'b0, 1'b1, 0);
      send(1, 8'h5A, 1'b1, 1'b1, 0);
      send(1, 8'h5A, 1'b0, 1'b1, 0);
      send(0, 8'h55, 1'b0, 1'b0, 0);
      check("frame_err_no_break", brk_cnt[0], 0);

      @(posedge clk); #1 ready = 1'b0;
      send(0, 8'h11, 1'b0, 1'b1, 0);
      send(0, 8'h22, 1'b0, 1'b1, 1);
      @(negedge clk);
      check("overrun_count", ovr_cnt[0], exp_ovr[0]);
      check("overrun_hold_valid", valid0, 1);
      check("overrun_hold_data", data0, 8'h11);
      @(posedge clk); #1 ready = 1'b1;
      repeat (2) @(negedge clk);
      check("valid_cleared", valid0, 0);

      drive(0, 1'b0); #2000;
      drive(0, 1'b1); #(2 * BT);
      check("glitch_no_valid", valid0, 0);
      drive(0, 1'b0); #(20 * BT);
      exp_brk[0]++;
      drive(0, 1'b1); #(3 * BT);
      check("break_count", brk_cnt[0], exp_brk[0]);
      check("break_valid_low", valid0, 0);
      send(0, 8'hA5, 1'b0, 1'b1, 0);

      drive(0, 1'b0); #BT;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1); #BT;
      end
      #(BT / 2);
      rst_n = 1'b0;
      #100;
      @(negedge clk);
      check("midframe_reset_out0", {data0, valid0, perr0, ferr0, ovr0, brk0}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      #(4 * BT);
      send(0, 8'h3C, 1'b0, 1'b1, 0);

      fork
         begin
            for (int k = 0; k < 8; k++)
               send(0, 8'($urandom), 1'b0, ($urandom_range(0, 3) != 0), 0);
         end
         begin
            for (int k = 0; k < 8; k++)
               send(1, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 0);
         end
      join

      for (int w = 0; w < 2000 && (q0.size() != 0 || q1.size() != 0); w++) @(negedge clk);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      check("break_total0", brk_cnt[0], exp_brk[0]);
      check("break_total1", brk_cnt[1], exp_brk[1]);
      check("overrun_total0", ovr_cnt[0], exp_ovr[0]);
      check("overrun_total1", ovr_cnt[1], exp_ovr[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 25_000_000, meaning the i_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the line bit rate.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, legal 5..9, meaning data bits per frame, sent LSB first.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, legal 1..2, meaning stop bits checked per frame.
REQ-006 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port uart_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-009 The block SHALL have port o_data, output, DATA_BITS bits: received word.
REQ-010 The block SHALL have port o_valid, output, 1 bit: o_data and error flags are valid.
REQ-011 The block SHALL have port i_ready, input, 1 bit: consumer accepts the word.
REQ-012 The block SHALL have port o_parity_err, output, 1 bit: parity mismatch; qualified by o_valid.
REQ-013 The block SHALL have port o_frame_err, output, 1 bit: a stop bit was sampled low; qualified by o_valid.
REQ-014 The block SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-015 The block SHALL have port o_break, output, 1 bit: one-cycle pulse when a break is detected.

Function
REQ-016 uart_rx SHALL pass through a 2-flop synchroniser before any use; both flops SHALL be preset to 1.
REQ-017 A 16x oversample tick SHALL come from a divider of DIV = round(CLK_FREQ/(16*BAUD)) clocks; DIV is 14 at defaults.
REQ-018 The divider SHALL restart on the first synchronised falling edge seen in IDLE.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PAR, STOP, and BRKWAIT.
REQ-020 Each bit value SHALL be the 2-of-3 majority of samples at ticks 7, 8, and 9 of that bit; the bit ends at tick 15.
REQ-021 In START, a majority-high start bit SHALL be treated as a glitch: return to IDLE and produce no output.
REQ-022 DATA SHALL shift DATA_BITS bits LSB first, then go to PAR if PARITY!=0, else to STOP.
REQ-023 Parity error: odd mode flags an even total ones count; even mode flags an odd total count (data plus parity bit).
REQ-024 STOP SHALL sample STOP_BITS bits; any low stop bit SHALL set frame_err.
REQ-025 The decision SHALL be made at tick 9 of the last stop bit; the FSM then returns to IDLE without waiting for tick 15.
REQ-026 o_valid, o_data, o_parity_err, and o_frame_err SHALL update exactly 1 clock after the decision cycle.
REQ-027 o_valid SHALL hold, with o_data and the flags stable, until a cycle with i_ready=1.
REQ-028 o_valid SHALL clear the cycle after acceptance unless a new word loads in that same cycle, in which case o_valid stays 1 with the new word.
REQ-029 A frame completing while o_valid=1 and i_ready=0 SHALL be dropped: the old word is kept and o_overrun pulses for 1 cycle.
REQ-030 Break: all data bits, the parity bit (if any), and all stop bits sampled low SHALL pulse o_break, leave o_valid unchanged, and enter BRKWAIT.
REQ-031 BRKWAIT SHALL return to IDLE only after the synchronised line has been high for 16 consecutive ticks.
REQ-032 The receiver SHALL never stall on i_ready; reception continues regardless of the consumer.

Reset
REQ-033 Asserting i_rst_n=0 at any time, including mid-frame, SHALL immediately force IDLE with divider and bit counters 0 and the shift register 0.
REQ-034 While in reset, outputs SHALL be o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_overrun=0, and o_break=0.
REQ-035 A frame interrupted by reset SHALL never produce o_valid; after release, the next falling edge starts a fresh frame.

Verification
REQ-036 Defaults, i_ready=1, send 0x5A 8N1 at 8680 ns/bit -> one o_valid pulse with o_data=0x5A and all error flags 0.
REQ-037 PARITY=2, send 0x5A with parity bit 1 -> o_data=0x5A, o_parity_err=1; then send it with parity bit 0 -> o_parity_err=0.
REQ-038 Send 0x55 with the stop bit low -> o_data=0x55, o_frame_err=1, o_break=0.
REQ-039 With i_ready=0, send 0x11 then 0x22 -> o_overrun pulses once, o_data stays 0x11; raising i_ready then clears o_valid.
REQ-040 Drive a 2 us low glitch, then hold the line low for 20 bit times -> no output for the glitch, one o_break pulse, o_valid=0; a following 0xA5 frame is received correctly.
REQ-041 Assert reset during bit 4 of 0xFF -> all outputs 0 and no o_valid; a following 0x3C frame is received correctly.
